// File: rtl/shiftrows_mixcols.sv
// AES round-datapath stage: ShiftRows on capture, then column-serial MixColumns.
// Sits between subbytes and AddRoundKey. The last_round flag skips MixColumns.
// Holds one block at a time, with a valid/ready handshake on both sides.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | empty; in_ready high, waiting for a block from subbytes
// MIX   | mixing COLS_PER_CYCLE columns per clock, starting at cnt_q
// DONE  | result presented on data_out until out_ready
module shiftrows_mixcols #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] sb_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         last_round,
  output logic [127:0] data_out,
  output logic         out_valid,
  input  logic         out_ready
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("shiftrows_mixcols: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] blk_q, blk_d;
  logic         last_q, last_d;
  logic         accept;
  logic [2:0]   cnt_end;
  logic         mix_last;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // byte k lives at [127-8k -: 8], row = k%4, col = k/4; row r rotates left by r
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  assign accept   = in_valid && in_ready;
  // cnt_end wraps to 0 in its low bits after column 3, which is the restart value
  assign cnt_end  = {1'b0, cnt_q} + 3'(COLS_PER_CYCLE);
  assign mix_last = cnt_end[2] || last_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = last_round ? DONE : MIX;
      MIX:     if (mix_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: only DONE exposes the state register
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    data_out  = out_valid ? blk_q : '0;
  end

  // datapath next values: capture with ShiftRows, then mix columns in place
  always_comb begin
    blk_d  = blk_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          blk_d  = shift_rows(sb_in);
          last_d = last_round;
          cnt_d  = '0;
        end
      end
      MIX: begin
        if (!last_q) begin
          for (int c = 0; c < 4; c++) begin
            if (c >= int'(cnt_q) && c < int'(cnt_end)) begin
              blk_d[127-32*c -: 32] = mix_col(blk_q[127-32*c -: 32]);
            end
          end
        end
        cnt_d = mix_last ? 2'd0 : cnt_end[1:0];
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      blk_q  <= blk_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_shiftrows_mixcols.sv
// Bench for shiftrows_mixcols: one instance at COLS_PER_CYCLE=1 carries most scenarios,
// two more at 2 and 4 check the wider configurations and their latency.
module tb_shiftrows_mixcols;

  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_MC  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] FIPS_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] COLV_IN  = {4{32'hdb135345}};
  localparam logic [127:0] COLV_OUT = {4{32'h8e4da1bc}};
  localparam logic [127:0] MISC_IN  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] sb_i, sb_w;
  logic         lv_i, lv_w, last_i, last_w, ordy_i, ordy_w;
  logic         ir1, ov1, ir2, ov2, ir4, ov4;
  logic [127:0] do1, do2, do4;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  logic [127:0] exp_q[$];
  int           acc_q[$];
  int           lat_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shiftrows_mixcols #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .sb_in(sb_i), .in_valid(lv_i), .in_ready(ir1),
    .last_round(last_i), .data_out(do1), .out_valid(ov1), .out_ready(ordy_i));

  shiftrows_mixcols #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .sb_in(sb_w), .in_valid(lv_w), .in_ready(ir2),
    .last_round(last_w), .data_out(do2), .out_valid(ov2), .out_ready(ordy_w));

  shiftrows_mixcols #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .sb_in(sb_w), .in_valid(lv_w), .in_ready(ir4),
    .last_round(last_w), .data_out(do4), .out_valid(ov4), .out_ready(ordy_w));

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s, input bit last);
    logic [7:0] m [4][4];
    logic [7:0] o [4][4];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = s[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[r][c] = m[r][(c+r)%4];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = o[0][c]; a1 = o[1][c]; a2 = o[2][c]; a3 = o[3][c];
        o[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        o[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        o[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        o[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = o[r][c];
    return res;
  endfunction

  task automatic test_reset();
    rst = 1'b1; lv_i = 1'b1; sb_i = FIPS_IN; ordy_i = 1'b1;
    lv_w = 1'b1; sb_w = FIPS_IN; ordy_w = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (ir1 !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", ir1); else pass_cnt++;
    total_cnt++; if (ov1 !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ov1); else pass_cnt++;
    total_cnt++; if (do1 !== 128'h0) $display("FAIL reset_data_out: got %h expected 0", do1); else pass_cnt++;
    total_cnt++; if ({ov2, ov4, do2 | do4} !== 130'h0) $display("FAIL reset_wide: got %b/%b %h expected 0", ov2, ov4, do2 | do4); else pass_cnt++;
    lv_i = 1'b0; lv_w = 1'b0; ordy_w = 1'b0;
    rst = 1'b0;
    #1;
    total_cnt++; if (ir1 !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", ir1); else pass_cnt++;
  endtask

  // single block through dut1 with out_ready high; scoreboard entry pushed on accept
  task automatic run_one(input logic [127:0] sb, input bit last, input logic [127:0] exp,
                         input int exp_lat, input string nm);
    int lat;
    bit rdy_low;
    logic [127:0] e;
    @(posedge clk); #1;
    sb_i = sb; last_i = last; lv_i = 1'b1; ordy_i = 1'b1;
    total_cnt++; if (ir1 !== 1'b1) $display("FAIL %s_ready_idle: got %b expected 1", nm, ir1); else pass_cnt++;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    lv_i = 1'b0; sb_i = ~sb; last_i = ~last;
    lat = 0; rdy_low = 1'b1;
    while (ov1 !== 1'b1 && lat < 20) begin
      if (ir1 !== 1'b0) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (ir1 !== 1'b0) rdy_low = 1'b0;
    e = exp_q.pop_front();
    total_cnt++;
    if (ov1 !== 1'b1) begin
      $display("FAIL %s_timeout: out_valid %b after %0d edges, expected 1", nm, ov1, lat);
      return;
    end else pass_cnt++;
    total_cnt++; if (lat != exp_lat) $display("FAIL %s_latency: got %0d expected %0d", nm, lat, exp_lat); else pass_cnt++;
    total_cnt++; if (do1 !== e) $display("FAIL %s_data: got %h expected %h", nm, do1, e); else pass_cnt++;
    total_cnt++; if (rdy_low !== 1'b1) $display("FAIL %s_ready_busy: got %b expected 1", nm, rdy_low); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if ({ov1, ir1} !== 2'b01) $display("FAIL %s_turnaround: got %b expected 01", nm, {ov1, ir1}); else pass_cnt++;
  endtask

  task automatic test_fips();
    run_one(FIPS_IN, 1'b0, FIPS_MC, 4, "fips_round");
    run_one(FIPS_IN, 1'b1, FIPS_SR, 0, "fips_last");
  endtask

  task automatic test_column_vector();
    int l2, l4;
    run_one(COLV_IN, 1'b0, COLV_OUT, 4, "colv_c1");
    foreach (exp_q[i]) ; // scoreboard is empty here
    // wider configurations: dut2 and dut4 share inputs
    for (int v = 0; v < 2; v++) begin
      logic [127:0] vin, vexp;
      vin  = (v == 0) ? COLV_IN : FIPS_IN;
      vexp = (v == 0) ? COLV_OUT : FIPS_MC;
      @(posedge clk); #1;
      sb_w = vin; last_w = 1'b0; lv_w = 1'b1; ordy_w = 1'b0;
      @(posedge clk); #1;
      lv_w = 1'b0; sb_w = ~vin;
      l2 = -1; l4 = -1;
      for (int e = 0; e <= 8; e++) begin
        if (ov2 === 1'b1 && l2 < 0) l2 = e;
        if (ov4 === 1'b1 && l4 < 0) l4 = e;
        @(posedge clk); #1;
      end
      total_cnt++; if (l2 != 2) $display("FAIL cpc2_latency_%0d: got %0d expected 2", v, l2); else pass_cnt++;
      total_cnt++; if (l4 != 1) $display("FAIL cpc4_latency_%0d: got %0d expected 1", v, l4); else pass_cnt++;
      total_cnt++; if (do2 !== vexp) $display("FAIL cpc2_data_%0d: got %h expected %h", v, do2, vexp); else pass_cnt++;
      total_cnt++; if (do4 !== vexp) $display("FAIL cpc4_data_%0d: got %h expected %h", v, do4, vexp); else pass_cnt++;
      ordy_w = 1'b1;
      @(posedge clk); #1;
      total_cnt++; if ({ov2, ov4, ir2, ir4} !== 4'b0011) $display("FAIL cpc_release_%0d: got %b expected 0011", v, {ov2, ov4, ir2, ir4}); else pass_cnt++;
      ordy_w = 1'b0;
    end
  endtask

  task automatic test_back_pressure();
    int t;
    bit held_ok;
    logic [127:0] first, e;
    @(posedge clk); #1;
    sb_i = FIPS_IN; last_i = 1'b0; lv_i = 1'b1; ordy_i = 1'b0;
    @(posedge clk);
    exp_q.push_back(FIPS_MC);
    #1;
    sb_i = MISC_IN; last_i = 1'b1;
    t = 0;
    while (ov1 !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    e = exp_q.pop_front();
    total_cnt++; if (ov1 !== 1'b1) $display("FAIL bp_timeout: got %b expected 1", ov1); else pass_cnt++;
    first = do1; held_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (ov1 !== 1'b1 || do1 !== first || ir1 !== 1'b0) held_ok = 1'b0;
    end
    total_cnt++; if (first !== e) $display("FAIL bp_data: got %h expected %h", first, e); else pass_cnt++;
    total_cnt++; if (held_ok !== 1'b1) $display("FAIL bp_hold: got %b expected 1 (now %h)", held_ok, do1); else pass_cnt++;
    ordy_i = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if ({ov1, ir1} !== 2'b01) $display("FAIL bp_release_idle: got %b expected 01", {ov1, ir1}); else pass_cnt++;
    @(posedge clk);
    exp_q.push_back(ref_model(MISC_IN, 1'b1));
    #1;
    lv_i = 1'b0;
    e = exp_q.pop_front();
    total_cnt++; if (ov1 !== 1'b1) $display("FAIL bp_new_valid: got %b expected 1", ov1); else pass_cnt++;
    total_cnt++; if (do1 !== e) $display("FAIL bp_new_data: got %h expected %h", do1, e); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mix();
    bit quiet;
    @(posedge clk); #1;
    sb_i = FIPS_IN; last_i = 1'b0; lv_i = 1'b1; ordy_i = 1'b1;
    @(posedge clk); #1;
    lv_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total_cnt++; if (ov1 !== 1'b0) $display("FAIL rstmix_out_valid: got %b expected 0", ov1); else pass_cnt++;
    total_cnt++; if (do1 !== 128'h0) $display("FAIL rstmix_data: got %h expected 0", do1); else pass_cnt++;
    total_cnt++; if (ir1 !== 1'b1) $display("FAIL rstmix_idle: got %b expected 1", ir1); else pass_cnt++;
    quiet = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (ov1 !== 1'b0) quiet = 1'b0; end
    total_cnt++; if (quiet !== 1'b1) $display("FAIL rstmix_dropped: got %b expected 1", quiet); else pass_cnt++;
    run_one(FIPS_IN, 1'b0, FIPS_MC, 4, "fips_after_rst");
  endtask

  task automatic test_back_to_back();
    logic [127:0] blks [3];
    bit           lst [3];
    blks = '{FIPS_IN, COLV_IN, MISC_IN};
    lst  = '{1'b0, 1'b1, 1'b0};
    @(posedge clk); #1;
    ordy_i = 1'b1;
    fork
      begin : drv
        for (int i = 0; i < 3; i++) begin
          int t;
          t = 0;
          sb_i = blks[i]; last_i = lst[i]; lv_i = 1'b1;
          while (ir1 !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
          @(posedge clk); #1;
          exp_q.push_back(ref_model(blks[i], lst[i]));
          lat_q.push_back(lst[i] ? 0 : 4);
          acc_q.push_back(cyc);
          lv_i = 1'b0;
        end
      end
      begin : rcv
        int got, w, l, el;
        logic [127:0] e;
        got = 0; w = 0;
        while (got < 3 && w < 200) begin
          @(negedge clk);
          w++;
          if (ov1 === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL b2b_unexpected: got %h expected none", do1);
            else begin
              pass_cnt++;
              e = exp_q.pop_front(); el = lat_q.pop_front(); l = cyc - acc_q.pop_front();
              total_cnt++; if (do1 !== e) $display("FAIL b2b_data_%0d: got %h expected %h", got, do1, e); else pass_cnt++;
              total_cnt++; if (l != el) $display("FAIL b2b_latency_%0d: got %0d expected %0d", got, l, el); else pass_cnt++;
            end
            got++;
          end
        end
        total_cnt++; if (got != 3) $display("FAIL b2b_count: got %0d expected 3", got); else pass_cnt++;
      end
    join
  endtask

  initial begin
    rst = 1'b1;
    sb_i = '0; lv_i = 1'b0; last_i = 1'b0; ordy_i = 1'b0;
    sb_w = '0; lv_w = 1'b0; last_w = 1'b0; ordy_w = 1'b0;
    test_reset();
    test_fips();
    test_column_vector();
    test_back_pressure();
    test_reset_mid_mix();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
